// File: rtl/rf_wr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rf_wr_arbiter_pkg
// Shared definitions for the register-file write arbiter:
//   - default address/data widths and requester count
//   - requester index constants (ALU writeback, load return, debug)
//   - FSM state encoding
//   - round-robin pointer advance helper
// -----------------------------------------------------------------------------
package rf_wr_arbiter_pkg;

  // Default geometry of the register file and the requester set.
  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;
  localparam int NREQ_DEF = 3;

  // Fixed requester slots.
  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_DBG  = 2;

  // RUN: normal arbitration. CLEAR: walking zero-fill of registers 1..max.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_e;

  // Round-robin pointer after requester idx wins, wrapping over n slots.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage : rf_wr_arbiter_pkg

// File: rtl/rf_wr_arbiter_rr_grant.sv
// -----------------------------------------------------------------------------
// rr_grant
// Purely combinational round-robin picker. Starting at slot ptr_i and moving
// upward with wrap-around, the first asserted request wins.
//
// Ports
//   req_i  [N-1:0]   request vector
//   ptr_i  [PW-1:0]  highest-priority slot this cycle (must be < N)
//   gnt_o  [N-1:0]   one-hot grant, all zero when no request is asserted
// -----------------------------------------------------------------------------
module rr_grant #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic found;
  int   slot;

  // NOTE: every signal driven from always_comb is given a default before any
  // conditional assignment; a path that leaves it unassigned infers a latch.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    slot  = 0;
    for (int k = 0; k < N; k++) begin
      slot = (int'(ptr_i) + k) % N;
      if (!found && req_i[slot]) begin
        gnt_o[slot] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule : rr_grant

// File: rtl/rf_wr_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wr_arbiter
// Arbitrates register-file write requests from up to NREQ requesters (ALU
// writeback, load return, debug) onto a single registered write port, and
// runs a clear sequence that zeroes registers 1..(2**AW-1) on request.
//
// Build option
//   RFARB_DEBUG_PORT_EN  when defined, the debug requester (slot 2) takes part
//                        in arbitration. When undefined, wr_ready_o[2] is tied
//                        low, wr_valid_i[2] is ignored and round-robin cycles
//                        over slots 0..1 only. Port widths never change.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   wr_valid_i   per-requester write request
//   wr_addr_i    per-requester destination register, slot i at [i*AW +: AW]
//   wr_data_i    per-requester write data, slot i at [i*DW +: DW]
//   wr_ready_o   one-hot grant (combinational); transfer = valid & ready
//   clr_req_i    one-cycle pulse starting a clear sequence
//   clr_busy_o   high while the FSM is in CLEAR
//   rf_rw_o      register-file write address   (registered)
//   rf_busw_o    register-file write data      (registered)
//   rf_regwr_o   register-file write enable    (registered)
//
// Timing
//   A transfer at edge N appears on the rf_* port during cycle N+1. In CLEAR
//   the counter value is loaded into the same output register, so the clear
//   writes of registers 1..31 appear one cycle behind the CLEAR cycles that
//   issue them. That lag leaves room for a transfer granted alongside clr_req
//   to drain through the output register before the first clear write.
// -----------------------------------------------------------------------------
module rf_wr_arbiter
  import rf_wr_arbiter_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int NREQ = NREQ_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    wr_valid_i,
  input  logic [NREQ*AW-1:0] wr_addr_i,
  input  logic [NREQ*DW-1:0] wr_data_i,
  output logic [NREQ-1:0]    wr_ready_o,
  input  logic               clr_req_i,
  output logic               clr_busy_o,
  output logic [AW-1:0]      rf_rw_o,
  output logic [DW-1:0]      rf_busw_o,
  output logic               rf_regwr_o
);

  // ---------------------------------------------------------------------------
  // Active requester set
  // ---------------------------------------------------------------------------
`ifdef RFARB_DEBUG_PORT_EN
  localparam int NACT = NREQ;
`else
  // Only slots below the debug slot arbitrate; the debug inputs are unused.
  localparam int NACT = REQ_DBG;

  logic unused_dbg_inputs;
  assign unused_dbg_inputs = ^{wr_valid_i[NREQ-1:NACT],
                               wr_addr_i[NREQ*AW-1:NACT*AW],
                               wr_data_i[NREQ*DW-1:NACT*DW]};
`endif

  localparam int            PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW-1:0] LAST_REG = '1;
  localparam logic [AW-1:0] FIRST_REG = AW'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  arb_state_e    state_q,    state_d;
  logic [PW-1:0] rr_ptr_q,   rr_ptr_d;
  logic [AW-1:0] clr_cnt_q,  clr_cnt_d;
  logic          rf_regwr_q, rf_regwr_d;
  logic [AW-1:0] rf_rw_q,    rf_rw_d;
  logic [DW-1:0] rf_busw_q,  rf_busw_d;

  // ---------------------------------------------------------------------------
  // Grant
  // ---------------------------------------------------------------------------
  logic [NACT-1:0] gnt_act;
  logic [NREQ-1:0] gnt;
  logic            xfer;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic [PW-1:0]   sel_idx;

  rr_grant #(
    .N  (NACT),
    .PW (PW)
  ) u_rr_grant (
    .req_i (wr_valid_i[NACT-1:0]),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt_act)
  );

  // Grants are only offered in RUN and never while reset is asserted, so no
  // handshake can complete in the reset cycle.
  always_comb begin
    gnt = '0;
    if (state_q == ST_RUN && !rst) begin
      gnt[NACT-1:0] = gnt_act;
    end
  end

  assign xfer = |gnt;

  // Route the winner's address/data to the output register.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_idx  = '0;
    for (int i = 0; i < NACT; i++) begin
      if (gnt[i]) begin
        sel_addr = wr_addr_i[i*AW +: AW];
        sel_data = wr_data_i[i*DW +: DW];
        sel_idx  = PW'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / output-register logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    clr_cnt_d  = clr_cnt_q;
    rf_regwr_d = 1'b0;
    rf_rw_d    = rf_rw_q;
    rf_busw_d  = rf_busw_q;

    unique case (state_q)
      ST_RUN: begin
        if (xfer) begin
          // Register 0 is hard-wired zero: the handshake completes, the write
          // enable stays low. Address/data still track the transfer.
          rf_regwr_d = (sel_addr != '0);
          rf_rw_d    = sel_addr;
          rf_busw_d  = sel_data;
          rr_ptr_d   = PW'(rr_next(int'(sel_idx), NACT));
        end
        // A transfer granted in this same cycle has already been captured above.
        if (clr_req_i) begin
          state_d = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        // clr_req_i is deliberately not looked at here: no restart, no queuing.
        rf_regwr_d = 1'b1;
        rf_rw_d    = clr_cnt_q;
        rf_busw_d  = '0;
        if (clr_cnt_q == LAST_REG) begin
          state_d   = ST_RUN;
          clr_cnt_d = FIRST_REG;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      rr_ptr_q   <= '0;
      clr_cnt_q  <= FIRST_REG;
      rf_regwr_q <= 1'b0;
      rf_rw_q    <= '0;
      rf_busw_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      clr_cnt_q  <= clr_cnt_d;
      rf_regwr_q <= rf_regwr_d;
      rf_rw_q    <= rf_rw_d;
      rf_busw_q  <= rf_busw_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign wr_ready_o = gnt;
  assign clr_busy_o = (state_q == ST_CLEAR) && !rst;
  assign rf_regwr_o = rf_regwr_q;
  assign rf_rw_o    = rf_rw_q;
  assign rf_busw_o  = rf_busw_q;

endmodule : rf_wr_arbiter

// File: tb/tb_rf_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wr_arbiter
// Self-checking bench for rf_wr_arbiter. A transaction-level model tracks the
// round-robin pointer, remaining clear writes and the expected write port; a
// compare process checks every output each cycle. Directed scenarios with
// hand-computed expectations run first, followed by constrained-random
// traffic with occasional clear requests and resets.
// Honours RFARB_DEBUG_PORT_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_rf_wr_arbiter;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREQ = 3;
`ifdef RFARB_DEBUG_PORT_EN
  localparam int NACT_M = 3;
`else
  localparam int NACT_M = 2;
`endif
  localparam int NCLR = 31;

  logic               clk      = 1'b0;
  logic               rst      = 1'b1;
  logic [NREQ-1:0]    wr_valid = '0;
  logic [NREQ*AW-1:0] wr_addr  = '0;
  logic [NREQ*DW-1:0] wr_data  = '0;
  logic               clr_req  = 1'b0;
  logic [NREQ-1:0]    wr_ready;
  logic               clr_busy;
  logic [AW-1:0]      rf_rw;
  logic [DW-1:0]      rf_busw;
  logic               rf_regwr;

  int n_checks = 0;
  int n_pass   = 0;

  rf_wr_arbiter #(
    .AW   (AW),
    .DW   (DW),
    .NREQ (NREQ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid_i (wr_valid),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .wr_ready_o (wr_ready),
    .clr_req_i  (clr_req),
    .clr_busy_o (clr_busy),
    .rf_rw_o    (rf_rw),
    .rf_busw_o  (rf_busw),
    .rf_regwr_o (rf_regwr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit              m_live = 1'b0;
  int              m_ptr = 0;
  int              m_clr_left = 0;   // clear writes still to be issued
  logic            m_regwr = 1'b0;
  logic [AW-1:0]   m_rw = '0;
  logic [DW-1:0]   m_busw = '0;
  logic [NREQ-1:0] m_gnt_last = '0;
  logic [NREQ-1:0] mg;
  logic [AW-1:0]   ma;
  logic [NREQ-1:0] exp_ready;

  // First valid requester at or after ptr among the active slots.
  function automatic logic [NREQ-1:0] model_grant(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NACT_M; k++) begin
      if (v[(ptr + k) % NACT_M]) return NREQ'(1) << ((ptr + k) % NACT_M);
    end
    return '0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_live = 1'b1; m_ptr = 0; m_clr_left = 0;
      m_regwr = 1'b0; m_rw = '0; m_busw = '0; m_gnt_last = '0;
    end else if (m_live) begin
      m_gnt_last = '0;
      if (m_clr_left > 0) begin
        m_regwr = 1'b1;
        m_rw    = AW'(NCLR + 1 - m_clr_left);
        m_busw  = '0;
        m_clr_left--;
      end else begin
        mg = model_grant(wr_valid, m_ptr);
        m_gnt_last = mg;
        m_regwr = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
          if (mg[i]) begin
            ma      = wr_addr[i*AW +: AW];
            m_regwr = (ma != '0);
            m_rw    = ma;
            m_busw  = wr_data[i*DW +: DW];
            m_ptr   = (i + 1) % NACT_M;
          end
        end
        if (clr_req) m_clr_left = NCLR;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      exp_ready = (rst || m_clr_left > 0) ? '0 : model_grant(wr_valid, m_ptr);
      check("model_wr_ready", 64'(wr_ready), 64'(exp_ready));
      check("model_clr_busy", 64'(clr_busy), 64'(!rst && m_clr_left > 0));
      check("model_rf_regwr", 64'(rf_regwr), 64'(m_regwr));
      check("model_rf_rw",    64'(rf_rw),    64'(m_rw));
      check("model_rf_busw",  64'(rf_busw),  64'(m_busw));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_addr[i*AW +: AW] = a;
    wr_data[i*DW +: DW] = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  bit free;

  initial begin
    // ---- reset: no grant in the reset cycle, outputs cleared afterwards ----
    wr_valid = 3'b011;
    mid();
    check("reset_ready", 64'(wr_ready), 64'(0));
    next_cycle();
    next_cycle();
    rst = 1'b0;
    wr_valid = '0;
    mid();
    check("reset_regwr", 64'(rf_regwr), 64'(0));
    check("reset_rw",    64'(rf_rw),    64'(0));
    check("reset_busw",  64'(rf_busw),  64'(0));
    check("reset_busy",  64'(clr_busy), 64'(0));

    // ---- contention from pointer 0 ----
    next_cycle();
    wr_valid = 3'b111;
    set_req(0, 5'd3, 32'hA0A0_0000);
    set_req(1, 5'd7, 32'hA1A1_1111);
    set_req(2, 5'd9, 32'hA2A2_2222);
    mid();
    check("cont_gnt0", 64'(wr_ready), 64'(3'b001));
    next_cycle();
    mid();
    check("cont_gnt1", 64'(wr_ready), 64'(3'b010));
    check("cont_rw0",  64'(rf_rw),    64'(3));
    check("cont_wr0",  64'(rf_regwr), 64'(1));
    check("cont_bw0",  64'(rf_busw),  64'(32'hA0A0_0000));
    next_cycle();
    mid();
`ifdef RFARB_DEBUG_PORT_EN
    check("cont_gnt2", 64'(wr_ready), 64'(3'b100));
`else
    check("cont_gnt2", 64'(wr_ready), 64'(3'b001));
`endif
    check("cont_rw1", 64'(rf_rw), 64'(7));
    next_cycle();
    wr_valid = '0;
    mid();
`ifdef RFARB_DEBUG_PORT_EN
    check("cont_rw2", 64'(rf_rw),   64'(9));
    check("cont_bw2", 64'(rf_busw), 64'(32'hA2A2_2222));
`else
    check("cont_rw2", 64'(rf_rw),   64'(3));
    check("cont_bw2", 64'(rf_busw), 64'(32'hA0A0_0000));
`endif
    check("idle_ready", 64'(wr_ready), 64'(0));

    // ---- single request ----
    next_cycle();
    wr_valid = 3'b001;
    set_req(0, 5'd5, 32'hDEAD_BEEF);
    mid();
    check("single_gnt", 64'(wr_ready), 64'(3'b001));
    next_cycle();
    wr_valid = '0;
    mid();
    check("single_wr",   64'(rf_regwr), 64'(1));
    check("single_rw",   64'(rf_rw),    64'(5));
    check("single_busw", 64'(rf_busw),  64'(32'hDEAD_BEEF));
    next_cycle();
    mid();
    check("hold_wr", 64'(rf_regwr), 64'(0));
    check("hold_rw", 64'(rf_rw),    64'(5));

    // ---- write to register 0 ----
    next_cycle();
    wr_valid = 3'b010;
    set_req(1, 5'd0, 32'h0000_1234);
    mid();
    check("zero_gnt", 64'(wr_ready), 64'(3'b010));
    next_cycle();
    wr_valid = '0;
    mid();
    check("zero_wr", 64'(rf_regwr), 64'(0));

    // ---- debug slot ----
    next_cycle();
    wr_valid = 3'b100;
    set_req(2, 5'd12, 32'hCAFE_0002);
`ifdef RFARB_DEBUG_PORT_EN
    mid();
    check("dbg_gnt", 64'(wr_ready), 64'(3'b100));
    next_cycle();
`else
    for (int c = 0; c < 5; c++) begin
      mid();
      check("dbg_off_ready", 64'(wr_ready), 64'(0));
      check("dbg_off_wr",    64'(rf_regwr), 64'(0));
      next_cycle();
    end
`endif
    wr_valid = '0;

    // ---- clear sequence (second clr_req mid-clear must be ignored) ----
    next_cycle();
    clr_req = 1'b1;
    mid();
    check("clr_start_busy", 64'(clr_busy), 64'(0));
    next_cycle();
    clr_req  = 1'b0;
    wr_valid = 3'b001;
    set_req(0, 5'd4, 32'h0000_0055);
    for (int k = 1; k <= NCLR; k++) begin
      mid();
      check("clr_busy",  64'(clr_busy), 64'(1));
      check("clr_ready", 64'(wr_ready), 64'(0));
      if (k >= 2) begin
        check("clr_wr",   64'(rf_regwr), 64'(1));
        check("clr_rw",   64'(rf_rw),    64'(k - 1));
        check("clr_busw", 64'(rf_busw),  64'(0));
      end
      next_cycle();
      clr_req = (k == 5);
    end
    mid();
    check("clr_end_busy",  64'(clr_busy), 64'(0));
    check("clr_end_rw",    64'(rf_rw),    64'(31));
    check("clr_end_wr",    64'(rf_regwr), 64'(1));
    check("clr_end_ready", 64'(wr_ready), 64'(3'b001));
    next_cycle();
    wr_valid = '0;
    mid();
    check("post_clr_rw",   64'(rf_rw),    64'(4));
    check("post_clr_busw", 64'(rf_busw),  64'(32'h55));
    check("post_clr_busy", 64'(clr_busy), 64'(0));

    // ---- reset in clear cycle 10 ----
    next_cycle();
    clr_req = 1'b1;
    next_cycle();
    clr_req = 1'b0;
    repeat (9) next_cycle();
    rst = 1'b1;
    mid();
    check("rstclr_ready", 64'(wr_ready), 64'(0));
    next_cycle();
    rst = 1'b0;
    wr_valid = 3'b111;
    mid();
    check("rstclr_wr",    64'(rf_regwr), 64'(0));
    check("rstclr_busy",  64'(clr_busy), 64'(0));
    check("rstclr_ptr0",  64'(wr_ready), 64'(3'b001));
    next_cycle();
    wr_valid = '0;
    mid();
    check("rstclr_rw", 64'(rf_rw), 64'(4));
    next_cycle();
    mid();
    check("rstclr_nowr", 64'(rf_regwr), 64'(0));

    // ---- random traffic ----
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      rst     = ($urandom_range(0, 299) == 0);
      clr_req = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NREQ; i++) begin
        // A pending (valid, not granted) request keeps its address and data.
        free = !wr_valid[i] || m_gnt_last[i];
        if (free) begin
          wr_valid[i] = 1'($urandom_range(0, 1));
          wr_addr[i*AW +: AW] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
          wr_data[i*DW +: DW] = $urandom;
        end else if ($urandom_range(0, 7) == 0) begin
          wr_valid[i] = 1'b0;
        end
      end
    end

    next_cycle();
    rst = 1'b0; clr_req = 1'b0; wr_valid = '0;
    mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_rf_wr_arbiter
